seq_shift_unit: RTL

Multi-cycle shift unit for the MIPS datapath executing SLL, SRL and SRA (plus op code 10, which is decoded as SRL) one bit position per clock. Right shifts complement the fixed left-by-2 offset shifter, and SRA reuses sign-fill semantics from sign extension. The unit sits beside the ALU in EX. Control starts it with a one-cycle `start`, stalls on `busy`, and captures `dout` on the `done` pulse.

---
 rtl/seq_shift_if.sv | 16 +
 rtl/seq_shift_unit.sv | 83 ++++++++
 2 files changed

// File: rtl/seq_shift_if.sv
// Handshake and data bundle between EX control and the multi-cycle shift unit.
interface seq_shift_if #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
);
  logic               start;
  logic [1:0]         op;
  logic [WIDTH-1:0]   din;
  logic [SHAMT_W-1:0] shamt;
  logic               busy;
  logic               done;
  logic [WIDTH-1:0]   dout;

  modport master (output start, op, din, shamt, input  busy, done, dout);
  modport slave  (input  start, op, din, shamt, output busy, done, dout);
endinterface

// File: rtl/seq_shift_unit.sv
// Bit-serial SLL/SRL/SRA unit: one bit position per clock, result and done
// pulse registered on the cycle the shift count runs out.
module seq_shift_unit #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic         clk,
  input  logic         rst,
  seq_shift_if.slave   bus
);

  // state   | meaning
  // S_IDLE  | waiting for start; done may be high for one cycle here
  // S_SHIFT | shifting one bit per clock until the counter reaches zero
  typedef enum logic {S_IDLE, S_SHIFT} state_t;

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRA = 2'b11;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   work_q,  work_d;
  logic [SHAMT_W-1:0] cnt_q,   cnt_d;
  logic [1:0]         op_q,    op_d;
  logic [WIDTH-1:0]   dout_q,  dout_d;
  logic               done_q,  done_d;

  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    dout_d  = dout_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          work_d  = bus.din;
          cnt_d   = bus.shamt;
          op_d    = bus.op;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - SHAMT_W'(1);
          case (op_q)
            OP_SLL:  work_d = {work_q[WIDTH-2:0], 1'b0};
            OP_SRA:  work_d = {work_q[WIDTH-1], work_q[WIDTH-1:1]};
            default: work_d = {1'b0, work_q[WIDTH-1:1]};  // op 01 and 10 both SRL
          endcase
        end else begin
          dout_d  = work_q;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      work_q  <= '0;
      cnt_q   <= '0;
      op_q    <= '0;
      dout_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      dout_q  <= dout_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy = (state_q == S_SHIFT);
  assign bus.done = done_q;
  assign bus.dout = dout_q;

endmodule
